// File: rtl/tod_cnt.sv
// BCD time-of-day counter: ms advance on tsc_1ppms, seconds..hours on tsc_1pps,
// with a validated software load that takes effect on the next PPS.
package types_pkg;
  typedef struct packed {
    logic [3:0] t_10h;
    logic [3:0] t_1h;
    logic [3:0] t_10m;
    logic [3:0] t_1m;
    logic [3:0] t_10s;
    logic [3:0] t_1s;
    logic [3:0] t_100ms;
    logic [3:0] t_10ms;
    logic [3:0] t_1ms;
  } time_t;
endpackage

module tod_cnt
  import types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  tsc_1ppms,
  input  logic  tsc_1pps,
  input  logic  set_stb,
  input  time_t set_time,
  output time_t cur_time,
  output logic  set_pend,
  output logic  set_err,
  output logic  sec_err,
  output logic  day_tick
);

  time_t hold_q;
  time_t time_nxt;
  time_t hold_nxt;
  logic  pend_nxt;
  logic  sec_err_nxt;
  logic  day_nxt;
  logic  set_ok;
  logic  ms_full;
  logic  carry;

  assign set_ok = (set_time.t_1s  <= 4'd9) && (set_time.t_10s <= 4'd5) &&
                  (set_time.t_1m  <= 4'd9) && (set_time.t_10m <= 4'd5) &&
                  (set_time.t_1h  <= 4'd9) && (set_time.t_10h <= 4'd2) &&
                  !((set_time.t_10h == 4'd2) && (set_time.t_1h > 4'd3));

  assign ms_full = (cur_time.t_100ms == 4'd9) && (cur_time.t_10ms == 4'd9) &&
                   (cur_time.t_1ms == 4'd9);

  always_comb begin
    time_nxt    = cur_time;
    sec_err_nxt = 1'b0;
    day_nxt     = 1'b0;
    carry       = 1'b0;

    if (tsc_1pps) begin
      time_nxt.t_1ms   = '0;
      time_nxt.t_10ms  = '0;
      time_nxt.t_100ms = '0;
      sec_err_nxt      = !ms_full;
      if (set_pend) begin
        time_nxt.t_1s  = hold_q.t_1s;
        time_nxt.t_10s = hold_q.t_10s;
        time_nxt.t_1m  = hold_q.t_1m;
        time_nxt.t_10m = hold_q.t_10m;
        time_nxt.t_1h  = hold_q.t_1h;
        time_nxt.t_10h = hold_q.t_10h;
      end else begin
        // ">=" limits make any out-of-range digit roll to 0 on its carry
        carry = 1'b1;
        if (cur_time.t_1s >= 4'd9) begin
          time_nxt.t_1s = '0;
        end else begin
          time_nxt.t_1s = cur_time.t_1s + 4'd1;
          carry         = 1'b0;
        end
        if (carry) begin
          if (cur_time.t_10s >= 4'd5) begin
            time_nxt.t_10s = '0;
          end else begin
            time_nxt.t_10s = cur_time.t_10s + 4'd1;
            carry          = 1'b0;
          end
        end
        if (carry) begin
          if (cur_time.t_1m >= 4'd9) begin
            time_nxt.t_1m = '0;
          end else begin
            time_nxt.t_1m = cur_time.t_1m + 4'd1;
            carry         = 1'b0;
          end
        end
        if (carry) begin
          if (cur_time.t_10m >= 4'd5) begin
            time_nxt.t_10m = '0;
          end else begin
            time_nxt.t_10m = cur_time.t_10m + 4'd1;
            carry          = 1'b0;
          end
        end
        if (carry) begin
          if ((cur_time.t_10h > 4'd2) ||
              ((cur_time.t_10h == 4'd2) && (cur_time.t_1h >= 4'd3))) begin
            time_nxt.t_1h  = '0;
            time_nxt.t_10h = '0;
            day_nxt        = 1'b1;
          end else if (cur_time.t_1h >= 4'd9) begin
            time_nxt.t_1h  = '0;
            time_nxt.t_10h = cur_time.t_10h + 4'd1;
          end else begin
            time_nxt.t_1h  = cur_time.t_1h + 4'd1;
          end
        end
      end
    end else if (tsc_1ppms && !ms_full) begin
      carry = 1'b1;
      if (cur_time.t_1ms >= 4'd9) begin
        time_nxt.t_1ms = '0;
      end else begin
        time_nxt.t_1ms = cur_time.t_1ms + 4'd1;
        carry          = 1'b0;
      end
      if (carry) begin
        if (cur_time.t_10ms >= 4'd9) begin
          time_nxt.t_10ms = '0;
        end else begin
          time_nxt.t_10ms = cur_time.t_10ms + 4'd1;
          carry           = 1'b0;
        end
      end
      if (carry) begin
        time_nxt.t_100ms = cur_time.t_100ms + 4'd1;
      end
    end
  end

  // The PPS consumes the old holding value; a coincident accepted strobe re-arms pend.
  always_comb begin
    hold_nxt = hold_q;
    pend_nxt = tsc_1pps ? 1'b0 : set_pend;
    if (set_stb && set_ok) begin
      hold_nxt         = set_time;
      hold_nxt.t_1ms   = '0;
      hold_nxt.t_10ms  = '0;
      hold_nxt.t_100ms = '0;
      pend_nxt         = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_time <= '0;
      hold_q   <= '0;
      set_pend <= 1'b0;
      set_err  <= 1'b0;
      sec_err  <= 1'b0;
      day_tick <= 1'b0;
    end else begin
      cur_time <= time_nxt;
      hold_q   <= hold_nxt;
      set_pend <= pend_nxt;
      set_err  <= set_stb && !set_ok;
      sec_err  <= sec_err_nxt;
      day_tick <= day_nxt;
    end
  end

endmodule

// File: tb/tb_tod_cnt.sv
// Directed-vector bench for tod_cnt: table of single-cycle stimuli with expected
// outputs, plus hand-written reset and multi-second alignment sequences.
module tb_tod_cnt;
  import types_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  tsc_1ppms = 1'b0;
  logic  tsc_1pps = 1'b0;
  logic  set_stb = 1'b0;
  time_t set_time = '0;
  time_t cur_time;
  logic  set_pend, set_err, sec_err, day_tick;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tod_cnt dut (
    .clk      (clk),
    .rst      (rst),
    .tsc_1ppms(tsc_1ppms),
    .tsc_1pps (tsc_1pps),
    .set_stb  (set_stb),
    .set_time (set_time),
    .cur_time (cur_time),
    .set_pend (set_pend),
    .set_err  (set_err),
    .sec_err  (sec_err),
    .day_tick (day_tick)
  );

  typedef struct {
    int    pre_ms;
    logic  ms;
    logic  pps;
    logic  stb;
    time_t st;
    time_t e_time;
    logic  e_pend;
    logic  e_serr;
    logic  e_sec;
    logic  e_day;
  } vec_t;

  vec_t tbl[$];

  function automatic time_t mk(int h, int m, int s, int ms);
    time_t t;
    t.t_10h   = 4'(h / 10);
    t.t_1h    = 4'(h % 10);
    t.t_10m   = 4'(m / 10);
    t.t_1m    = 4'(m % 10);
    t.t_10s   = 4'(s / 10);
    t.t_1s    = 4'(s % 10);
    t.t_100ms = 4'(ms / 100);
    t.t_10ms  = 4'((ms / 10) % 10);
    t.t_1ms   = 4'(ms % 10);
    return t;
  endfunction

  task automatic add(int pre, logic ms, logic pps, logic stb, time_t st,
                     time_t et, logic ep, logic eserr, logic esec, logic eday);
    vec_t v;
    v.pre_ms = pre; v.ms = ms; v.pps = pps; v.stb = stb; v.st = st;
    v.e_time = et; v.e_pend = ep; v.e_serr = eserr; v.e_sec = esec; v.e_day = eday;
    tbl.push_back(v);
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(logic ms, logic pps, logic stb, time_t st);
    @(negedge clk);
    tsc_1ppms = ms;
    tsc_1pps  = pps;
    set_stb   = stb;
    set_time  = st;
    @(posedge clk);
    #1;
    tsc_1ppms = 1'b0;
    tsc_1pps  = 1'b0;
    set_stb   = 1'b0;
    set_time  = '0;
  endtask

  initial begin
    time_t z, bad_digit;
    logic  sec_seen;
    z = '0;
    bad_digit = mk(1, 2, 3, 0);
    bad_digit.t_1s = 4'hA;

    //   pre  ms  pps stb set_time            exp time             pend serr sec day
    add(998, 1, 0, 0, z,                  mk(0, 0, 0, 999),    0, 0, 0, 0);
    add(0,   1, 0, 0, z,                  mk(0, 0, 0, 999),    0, 0, 0, 0);
    add(0,   1, 1, 0, z,                  mk(0, 0, 1, 0),      0, 0, 0, 0);
    add(0,   0, 0, 0, z,                  mk(0, 0, 1, 0),      0, 0, 0, 0);
    add(499, 1, 0, 0, z,                  mk(0, 0, 1, 500),    0, 0, 0, 0);
    add(0,   0, 1, 0, z,                  mk(0, 0, 2, 0),      0, 0, 1, 0);
    add(0,   0, 0, 0, z,                  mk(0, 0, 2, 0),      0, 0, 0, 0);
    add(0,   0, 0, 1, mk(12, 34, 56, 777), mk(0, 0, 2, 0),     1, 0, 0, 0);
    add(0,   0, 1, 0, z,                  mk(12, 34, 56, 0),   0, 0, 1, 0);
    add(0,   0, 1, 0, z,                  mk(12, 34, 57, 0),   0, 0, 1, 0);
    add(0,   0, 0, 1, mk(23, 59, 59, 0),  mk(12, 34, 57, 0),   1, 0, 0, 0);
    add(0,   0, 1, 0, z,                  mk(23, 59, 59, 0),   0, 0, 1, 0);
    add(0,   0, 1, 0, z,                  mk(0, 0, 0, 0),      0, 0, 1, 1);
    add(0,   0, 0, 0, z,                  mk(0, 0, 0, 0),      0, 0, 0, 0);
    add(0,   0, 0, 1, mk(9, 59, 59, 0),   mk(0, 0, 0, 0),      1, 0, 0, 0);
    add(0,   0, 1, 0, z,                  mk(9, 59, 59, 0),    0, 0, 1, 0);
    add(0,   0, 1, 0, z,                  mk(10, 0, 0, 0),     0, 0, 1, 0);
    add(0,   0, 0, 1, mk(24, 0, 0, 0),    mk(10, 0, 0, 0),     0, 1, 0, 0);
    add(0,   0, 0, 1, mk(10, 60, 0, 0),   mk(10, 0, 0, 0),     0, 1, 0, 0);
    add(0,   0, 0, 1, bad_digit,          mk(10, 0, 0, 0),     0, 1, 0, 0);
    add(0,   0, 0, 1, mk(23, 59, 60, 0),  mk(10, 0, 0, 0),     0, 1, 0, 0);
    add(0,   0, 0, 0, z,                  mk(10, 0, 0, 0),     0, 0, 0, 0);
    add(0,   0, 0, 1, mk(19, 59, 59, 0),  mk(10, 0, 0, 0),     1, 0, 0, 0);
    add(0,   0, 1, 0, z,                  mk(19, 59, 59, 0),   0, 0, 1, 0);
    add(0,   0, 1, 0, z,                  mk(20, 0, 0, 0),     0, 0, 1, 0);
    add(0,   0, 1, 1, mk(1, 2, 3, 0),     mk(20, 0, 1, 0),     1, 0, 1, 0);
    add(0,   0, 1, 0, z,                  mk(1, 2, 3, 0),      0, 0, 1, 0);
    add(0,   0, 0, 1, mk(5, 0, 0, 0),     mk(1, 2, 3, 0),      1, 0, 0, 0);
    add(0,   0, 0, 1, mk(6, 0, 0, 0),     mk(1, 2, 3, 0),      1, 0, 0, 0);
    add(0,   0, 1, 1, mk(7, 0, 0, 0),     mk(6, 0, 0, 0),      1, 0, 1, 0);
    add(0,   0, 1, 0, z,                  mk(7, 0, 0, 0),      0, 0, 1, 0);
    add(0,   0, 1, 0, z,                  mk(7, 0, 1, 0),      0, 0, 1, 0);
    add(0,   1, 0, 0, z,                  mk(7, 0, 1, 1),      0, 0, 0, 0);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst time", 64'(cur_time), 64'(z));
    chk("rst pend", 64'(set_pend), 64'd0);
    chk("rst pulses", 64'({set_err, sec_err, day_tick}), 64'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].pre_ms; k++) step(1'b1, 1'b0, 1'b0, z);
      step(tbl[i].ms, tbl[i].pps, tbl[i].stb, tbl[i].st);
      chk($sformatf("v%0d time", i), 64'(cur_time), 64'(tbl[i].e_time));
      chk($sformatf("v%0d set_pend", i), 64'(set_pend), 64'(tbl[i].e_pend));
      chk($sformatf("v%0d set_err", i), 64'(set_err), 64'(tbl[i].e_serr));
      chk($sformatf("v%0d sec_err", i), 64'(sec_err), 64'(tbl[i].e_sec));
      chk($sformatf("v%0d day_tick", i), 64'(day_tick), 64'(tbl[i].e_day));
    end

    // asynchronous reset mid-cycle with a load pending
    step(1'b0, 1'b0, 1'b1, mk(3, 3, 3, 0));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst time", 64'(cur_time), 64'(z));
    chk("async rst pend", 64'(set_pend), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, z);
    chk("post rst ms", 64'(cur_time), 64'(mk(0, 0, 0, 1)));
    step(1'b0, 1'b1, 1'b0, z);
    chk("post rst no load", 64'(cur_time), 64'(mk(0, 0, 1, 0)));

    // five aligned seconds: ms tick every 2 cycles, PPS on every 1000th ms tick
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      sec_seen = 1'b0;
      for (int k = 1; k <= 1000; k++) begin
        step(1'b1, (k == 1000), 1'b0, z);
        sec_seen |= sec_err;
        step(1'b0, 1'b0, 1'b0, z);
        sec_seen |= sec_err;
      end
      chk($sformatf("sec%0d time", s), 64'(cur_time), 64'(mk(0, 0, s, 0)));
      chk($sformatf("sec%0d sec_err", s), 64'(sec_seen), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
